// File: rtl/uart_frame_arbiter_if.sv
// Byte-stream requesters and the UART TX byte port, bundled for uart_frame_arbiter.
// A req byte moves on a cycle where req_valid[i] && req_ready[i]; req_ready never waits on req_valid.
interface uart_frame_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 uart_start;
  logic [7:0]           uart_data;
  logic                 uart_ready;
  logic                 uart_busy;

  modport master (
    output req_valid, req_data, req_last, uart_ready, uart_busy,
    input  req_ready, uart_start, uart_data
  );

  modport slave (
    input  req_valid, req_data, req_last, uart_ready, uart_busy,
    output req_ready, uart_start, uart_data
  );
endinterface

// File: rtl/uart_frame_arbiter.sv
// Round-robin, frame-atomic arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Optional mid-frame stall abort: define UART_ARB_TIMEOUT_EN.
module uart_frame_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic                       i_sclk,
  input  logic                       i_rst,
  uart_frame_arbiter_if.slave        bus,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id,
  output logic                       o_active,
  output logic [2:0]                 o_state
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                       o_timeout_err
`endif
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_SEND  = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("uart_frame_arbiter: NUM_REQ must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1 || CW < 1) begin : g_bad_timeout
    $error("uart_frame_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  state_t            r_state;
  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     r_grant_id;
  logic              r_uart_start;
  logic [7:0]        r_uart_data;
  logic              r_last_q;

  logic              w_any;
  logic [GW-1:0]     w_pick;
  logic              w_tx_free;
  logic              w_sel_valid;
  logic              w_xfer;
  logic [NUM_REQ-1:0] w_req_ready;

  // Scan rr_ptr+1, rr_ptr+2, ... so the last-served requester is considered last.
  always_comb begin
    int idx;
    w_any  = 1'b0;
    w_pick = '0;
    idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_any && bus.req_valid[idx]) begin
        w_any  = 1'b1;
        w_pick = GW'(idx);
      end
    end
  end

  assign w_tx_free   = bus.uart_ready && !bus.uart_busy;
  assign w_sel_valid = bus.req_valid[r_grant_id];
  assign w_xfer      = (r_state == S_GRANT) && w_sel_valid && w_tx_free;

  always_comb begin
    w_req_ready = '0;
    if (r_state == S_GRANT) w_req_ready[r_grant_id] = w_tx_free;
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [CW-1:0] r_stall_cnt;
  logic          r_timeout_err;
  assign o_timeout_err = r_timeout_err;
`endif

  always_ff @(posedge i_sclk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= GW'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_uart_start <= 1'b0;
      r_uart_data  <= '0;
      r_last_q     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_uart_start <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_id <= w_pick;
            r_state    <= S_GRANT;
`ifdef UART_ARB_TIMEOUT_EN
            r_stall_cnt <= '0;
`endif
          end
        end
        S_GRANT: begin
          if (w_xfer) begin
            r_uart_data  <= bus.req_data[{r_grant_id, 3'b000} +: 8];
            r_last_q     <= bus.req_last[r_grant_id];
            r_uart_start <= 1'b1;
            r_state      <= S_SEND;
`ifdef UART_ARB_TIMEOUT_EN
            r_stall_cnt  <= '0;
          end else if (!w_sel_valid) begin
            // Only cycles with the owner's valid low count as a stall.
            if (r_stall_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
              r_state       <= S_IDLE;
              r_rr_ptr      <= r_grant_id;
              r_timeout_err <= 1'b1;
            end else begin
              r_stall_cnt <= r_stall_cnt + 1'b1;
            end
`endif
          end
        end
        S_SEND: r_state <= S_HOLD;
        // Transmitter drops ready one cycle after start; skip that stale cycle.
        S_HOLD: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_tx_free) begin
            if (r_last_q) begin
              r_rr_ptr <= r_grant_id;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_GRANT;
`ifdef UART_ARB_TIMEOUT_EN
              r_stall_cnt <= '0;
`endif
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.uart_start = r_uart_start;
  assign bus.uart_data  = r_uart_data;
  assign o_grant_id     = r_grant_id;
  assign o_active       = (r_state != S_IDLE);
  assign o_state        = r_state;
endmodule
